rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Owns the single write port (we3/a3/wd3) of the 32x32 register file and shares it between two requesters:
//  - the pipeline writeback stage (WB): fixed priority, no backpressure
//  - a long-latency unit (LU, e.g. mul/div): valid/ready, buffered in a small FIFO
//  Keeps a pending-register scoreboard so decode can stall on LU results; forces a WB stall if the LU starves.
// PARAMETERS
//  DEPTH         2  LU write FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4  cycles a non-empty FIFO head may wait before wb_stall asserts (>=1)
// PORTS
//  Clock and reset: one clock; reset is synchronous and active-high.
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous active-high reset
//  wb_we       in   1   WB write request this cycle
//  wb_rd       in   5   WB destination register
//  wb_data     in   32  WB write data
//  lu_valid    in   1   LU result valid
//  lu_ready    out  1   FIFO can accept (= !full; registered state only, no path from lu_valid)
//  lu_rd       in   5   LU destination register
//  lu_data     in   32  LU result data
//  sb_set      in   1   decode issued an LU op; mark sb_rd pending
//  sb_rd       in   5   register to mark pending
//  rs1_addr    in   5   scoreboard query: source 1
//  rs2_addr    in   5   scoreboard query: source 2
//  rd_addr     in   5   scoreboard query: destination (WAW check)
//  rs1_busy    out  1   pending[rs1_addr], combinational
//  rs2_busy    out  1   pending[rs2_addr], combinational
//  rd_busy     out  1   pending[rd_addr], combinational
//  wb_stall    out  1   request pipeline to hold WB idle (starvation relief)
//  rf_we       out  1   to regfile we3
//  rf_waddr    out  5   to regfile a3
//  rf_wdata    out  32  to regfile wd3
//  fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
//  err_waw     out  1   sticky; WB wrote a register pending in the scoreboard
// BEHAVIOUR
//  Reset: FIFO empty, fifo_count=0, pending=0, starve counter=0, err_waw=0, wb_stall=0, lu_ready=1.
//   rf_we=0 while rst=1.
//  Port select (combinational, same cycle):
//   - wb_use = wb_we && wb_rd!=0
//   - if wb_use: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data
//   - else if FIFO non-empty: pop head; rf_we=(head.rd!=0), rf_waddr/rf_wdata from head
//   - else rf_we=0 (rf_waddr/rf_wdata = 0)
//  x0: never written. A WB write to x0 does not occupy the port; an LU entry with rd=0 pops with rf_we=0.
//  Push: lu_valid && lu_ready writes the tail. An entry accepted in cycle N reaches the port no earlier than N+1 (no bypass).
//   Push and pop in the same cycle are allowed; count unchanged.
//   When full, lu_ready=0 even if a pop occurs that cycle.
//  Scoreboard (pending[31:0]):
//   - sb_set sets pending[sb_rd] (ignored for sb_rd=0)
//   - a pop of an entry with rd=r clears pending[r]
//   - set and clear of the same r in one cycle: set wins
//   - pending[0] is always 0
//  Starvation:
//   - counter increments each cycle the FIFO is non-empty and no pop occurs; it clears on pop or when the FIFO is empty
//   - wb_stall = (counter >= STARVE_LIMIT), registered
//   - WB still wins if wb_we stays high while stalled (pipeline contract violation, no data loss)
//  err_waw: set when wb_use && pending[wb_rd]. Cleared only by rst.
//  Reset mid-operation: all FIFO contents and pending bits are discarded. No write issues in the reset cycle.
// TESTING
//  1 WB only: wb_we=1, rd=5, data=0xA5A5A5A5 -> rf_we=1, waddr=5 same cycle; wb_rd=0 -> rf_we=0.
//  2 LU drain: push rd=7, data=0x11 at cycle N with WB idle -> rf_we=1, waddr=7 at N+1; fifo_count 1->0.
//  3 Contention: WB busy every cycle, push rd=3 -> no pop; wb_stall=1 after 4 cycles; drop wb_we -> pop, wb_stall=0 next cycle.
//  4 Full/backpressure (DEPTH=2): two pushes while WB busy -> lu_ready=0, third lu_valid not accepted; one pop -> lu_ready=1 next cycle.
//  5 Scoreboard: sb_set rd=9 -> rs1_busy=1 for rs1_addr=9; LU pop rd=9 with same-cycle sb_set rd=9 -> stays 1; WB to x9 sets err_waw.
//  6 Reset mid-op: FIFO count=2, pending[4]=1, rst=1 for 1 cycle -> count=0, busy=0, rf_we=0, lu_ready=1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the writeback stage (fixed priority)
// and a FIFO-buffered long-latency unit, with a pending-register scoreboard and starvation relief.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [4:0]                 lu_rd,
    input  logic [31:0]                lu_data,
    input  logic                       sb_set,
    input  logic [4:0]                 sb_rd,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    input  logic [4:0]                 rd_addr,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic                       rd_busy,
    output logic                       wb_stall,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       err_waw
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [31:0]   pending_q;
    logic [31:0]   pending_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          wb_stall_q;
    logic          err_waw_q;

    logic          wb_use;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // lu_ready depends only on registered occupancy, never on this cycle's pop.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign lu_ready   = !fifo_full;
    assign push       = lu_valid && !fifo_full && !rst;
    assign wb_use     = wb_we && (wb_rd != 5'd0) && !rst;
    assign pop        = !rst && !wb_use && !fifo_empty;
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_use) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (pop) begin
            rf_we    = (head_rd != 5'd0);
            rf_waddr = head_rd;
            rf_wdata = head_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Saturating wait counter for the FIFO head.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // A same-cycle set overrides the clear from a popped entry.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pending_d[gi] = 1'b0;
            end else begin : g_rn
                logic set_hit;
                logic clr_hit;
                assign set_hit       = sb_set && (sb_rd == 5'(gi));
                assign clr_hit       = pop && (head_rd == 5'(gi));
                assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            starve_q   <= '0;
            wb_stall_q <= 1'b0;
            err_waw_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            wb_stall_q <= (starve_d >= SW'(STARVE_LIMIT));
            if (wb_use && pending_q[wb_rd]) begin
                err_waw_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= lu_rd;
            fifo_data_q[wr_ptr_q] <= lu_data;
        end
    end

    assign fifo_count = count_q;
    assign rs1_busy   = pending_q[rs1_addr];
    assign rs2_busy   = pending_q[rs2_addr];
    assign rd_busy    = pending_q[rd_addr];
    assign wb_stall   = wb_stall_q;
    assign err_waw    = err_waw_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the port-sharing rules.
module tb_rf_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_rd = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic        rs1_busy, rs2_busy, rd_busy, wb_stall, rf_we, err_waw;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count), .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending LU results, a pending-register set,
    // and a count of cycles the oldest result has been kept waiting.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] m_pend  = '0;
    int        m_wait  = 0;
    bit        m_stall = 1'b0;
    bit        m_err   = 1'b0;

    logic        e_we, e_ready, e_r1, e_r2, e_rd;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;

    function automatic void model_eval();
        bit wbu;
        wbu     = wb_we && (wb_rd != 5'd0);
        e_ready = (mq.size() < DEPTH);
        e_cnt   = 2'(mq.size());
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        if (!rst) begin
            if (wbu) begin
                e_we   = 1'b1;
                e_addr = wb_rd;
                e_data = wb_data;
            end else if (mq.size() > 0) begin
                e_we   = (mq[0].rd != 5'd0);
                e_addr = mq[0].rd;
                e_data = mq[0].data;
            end
        end
        e_r1 = m_pend[rs1_addr];
        e_r2 = m_pend[rs2_addr];
        e_rd = m_pend[rd_addr];
    endfunction

    function automatic void model_step();
        bit wbu, pop, push;
        int sz;
        if (rst) begin
            mq.delete();
            m_pend  = '0;
            m_wait  = 0;
            m_stall = 1'b0;
            m_err   = 1'b0;
            return;
        end
        sz   = mq.size();
        wbu  = wb_we && (wb_rd != 5'd0);
        pop  = !wbu && (sz > 0);
        push = lu_valid && (sz < DEPTH);
        if (wbu && m_pend[wb_rd]) m_err = 1'b1;
        if (pop) begin
            m_pend[mq[0].rd] = 1'b0;
            void'(mq.pop_front());
        end
        if (sb_set && sb_rd != 5'd0) m_pend[sb_rd] = 1'b1;
        if (push) mq.push_back('{rd: lu_rd, data: lu_data});
        if (pop || sz == 0) m_wait = 0;
        else m_wait++;
        m_stall = (m_wait >= LIMIT);
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        tick(); tick();
        rst = 1'b0; wb_we = 1'b0;
        #1;
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready: got %b want 1", lu_ready); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", wb_stall); end
        checks++; if (err_waw !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_waw); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_idle_we: got %b want 0", rf_we); end
        $display("reset: count=%0d ready=%b stall=%b", fifo_count, lu_ready, wb_stall);
    endtask

    task automatic test_wb_only();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5_A5A5;
        #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hA5A5_A5A5})
            begin errors++; $display("FAIL wb_write: got we=%b a=%0d d=%h want 1/5/a5a5a5a5", rf_we, rf_waddr, rf_wdata); end
        $display("wb write: we=%b addr=%0d data=%h", rf_we, rf_waddr, rf_wdata);
        tick();
        wb_rd = 5'd0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wb_x0: got we=%b want 0", rf_we); end
        $display("wb x0: we=%b", rf_we);
        tick();
        wb_we = 1'b0;
    endtask

    task automatic test_lu_drain();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h11;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_bypass: got we=%b want 0", rf_we); end
        tick();
        lu_valid = 1'b0;
        #1;
        checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL drain_count1: got %0d want 1", fifo_count); end
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h11})
            begin errors++; $display("FAIL drain_pop: got we=%b a=%0d d=%h want 1/7/11", rf_we, rf_waddr, rf_wdata); end
        $display("lu drain: we=%b addr=%0d data=%h count=%0d", rf_we, rf_waddr, rf_wdata, fifo_count);
        tick();
        #1;
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL drain_count0: got %0d want 0", fifo_count); end
    endtask

    task automatic test_contention();
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
        #1;
        checks++; if (rf_waddr !== 5'd1) begin errors++; $display("FAIL cont_wb_wins: got a=%0d want 1", rf_waddr); end
        tick();
        lu_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            checks++; if (wb_stall !== logic'(i >= 5))
                begin errors++; $display("FAIL cont_stall_%0d: got %b want %b", i, wb_stall, i >= 5); end
            checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL cont_count_%0d: got %0d want 1", i, fifo_count); end
            $display("contention cycle %0d: stall=%b count=%0d", i, wb_stall, fifo_count);
            tick();
        end
        wb_we = 1'b0;
        #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33})
            begin errors++; $display("FAIL cont_pop: got we=%b a=%0d d=%h want 1/3/33", rf_we, rf_waddr, rf_wdata); end
        tick();
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL cont_unstall: got %b want 0", wb_stall); end
        $display("contention release: stall=%b count=%0d", wb_stall, fifo_count);
    endtask

    task automatic test_full();
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h2;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA;
        tick();
        lu_rd = 5'd11; lu_data = 32'hB;
        #1;
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %b want 1", lu_ready); end
        tick();
        lu_rd = 5'd12; lu_data = 32'hC;
        #1;
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready0: got %b want 0", lu_ready); end
        tick();
        lu_valid = 1'b0;
        #1;
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d want 2", fifo_count); end
        wb_we = 1'b0;
        #1;
        checks++; if (rf_waddr !== 5'd10 || lu_ready !== 1'b0)
            begin errors++; $display("FAIL full_pop1: got a=%0d ready=%b want 10/0", rf_waddr, lu_ready); end
        tick();
        #1;
        checks++; if (lu_ready !== 1'b1 || fifo_count !== 2'd1)
            begin errors++; $display("FAIL full_reopen: got ready=%b count=%0d want 1/1", lu_ready, fifo_count); end
        checks++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'hB)
            begin errors++; $display("FAIL full_pop2: got a=%0d d=%h want 11/b", rf_waddr, rf_wdata); end
        $display("full: second pop addr=%0d count=%0d", rf_waddr, fifo_count);
        tick();
        #1;
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_rd = 5'd9;
        tick();
        sb_set = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd8; rd_addr = 5'd9;
        #1;
        checks++; if ({rs1_busy, rs2_busy, rd_busy} !== 3'b101)
            begin errors++; $display("FAIL sb_query: got %b%b%b want 101", rs1_busy, rs2_busy, rd_busy); end
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        tick();
        lu_valid = 1'b0; sb_set = 1'b1; sb_rd = 5'd9;
        #1;
        checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL sb_pop: got a=%0d want 9", rf_waddr); end
        tick();
        sb_set = 1'b0;
        #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", rs1_busy); end
        lu_valid = 1'b1;
        tick();
        lu_valid = 1'b0;
        tick();
        #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", rs1_busy); end
        sb_set = 1'b1; sb_rd = 5'd0; rs1_addr = 5'd0;
        tick();
        #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_x0: got %b want 0", rs1_busy); end
        sb_rd = 5'd9;
        tick();
        sb_set = 1'b0; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h5;
        #1;
        checks++; if (err_waw !== 1'b0) begin errors++; $display("FAIL sb_err_early: got %b want 0", err_waw); end
        tick();
        wb_we = 1'b0;
        tick();
        #1;
        checks++; if (err_waw !== 1'b1) begin errors++; $display("FAIL sb_err_waw: got %b want 1", err_waw); end
        $display("scoreboard: err_waw=%b", err_waw);
    endtask

    task automatic test_reset_midop();
        wb_we = 1'b1; wb_rd = 5'd2;
        lu_valid = 1'b1; lu_rd = 5'd4; sb_set = 1'b1; sb_rd = 5'd4;
        tick();
        lu_rd = 5'd5; sb_set = 1'b0;
        tick();
        lu_valid = 1'b0; rs1_addr = 5'd4;
        #1;
        checks++; if (fifo_count !== 2'd2 || rs1_busy !== 1'b1)
            begin errors++; $display("FAIL midop_pre: got count=%0d busy=%b want 2/1", fifo_count, rs1_busy); end
        rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midop_rst_we: got %b want 0", rf_we); end
        tick();
        rst = 1'b0; wb_we = 1'b0;
        #1;
        checks++; if ({fifo_count, rs1_busy, rf_we, lu_ready, err_waw} !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b0})
            begin errors++; $display("FAIL midop_post: got count=%0d busy=%b we=%b ready=%b err=%b want 0/0/0/1/0",
                fifo_count, rs1_busy, rf_we, lu_ready, err_waw); end
        $display("reset mid-op: count=%0d busy=%b ready=%b", fifo_count, rs1_busy, lu_ready);
    endtask

    task automatic test_random();
        logic [47:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wb_we    = ($urandom_range(0, 9) < 6);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            lu_valid = $urandom_range(0, 1);
            lu_rd    = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            sb_set   = ($urandom_range(0, 3) == 0);
            sb_rd    = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            rd_addr  = 5'($urandom_range(0, 7));
            #1;
            model_eval();
            got = {rf_we, rf_waddr, rf_wdata, lu_ready, fifo_count, rs1_busy, rs2_busy, rd_busy, wb_stall, err_waw};
            exp = {e_we, e_addr, e_data, e_ready, e_cnt, e_r1, e_r2, e_rd, m_stall, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h", n, got, exp);
            end else begin
                $display("random %0d: we=%b addr=%0d count=%0d stall=%b", n, rf_we, rf_waddr, fifo_count, wb_stall);
            end
            tick();
        end
        rst = 1'b0; wb_we = 1'b0; lu_valid = 1'b0; sb_set = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wb_only();
        test_lu_drain();
        test_contention();
        test_full();
        test_scoreboard();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
